// File: rtl/booth_r4_mul.sv
// Sequential radix-4 (modified) Booth multiplier with valid/ready handshakes on both sides.
// Signed or unsigned operation is chosen per operand set and captured with the operands.
module booth_r4_mul #(
   parameter int OPERAND_BITS = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic                        signed_mode,
   input  logic [OPERAND_BITS-1:0]     mul_a,
   input  logic [OPERAND_BITS-1:0]     mul_b,
   input  logic                        flush,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [2*OPERAND_BITS-1:0]   product,
   output logic                        busy
);

   localparam int N     = OPERAND_BITS;
   localparam int X     = N + 1;
   localparam int XP    = X + (X % 2);
   localparam int ITER  = XP / 2;
   localparam int ACC_W = 2 * XP;
   localparam int CNT_W = $clog2(ITER + 1) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state, state_nxt;
   logic [ACC_W-1:0]   acc;
   logic [ACC_W-1:0]   a_sh;
   logic [XP-1:0]      b_sh;
   logic               b_prev;
   logic [CNT_W-1:0]   cnt;
   logic               last;
   logic [ACC_W-1:0]   mag;
   logic [ACC_W-1:0]   addend;
   logic               neg;

   // One extra BUSY cycle after the last add moves the result into product.
   assign last = (cnt == CNT_W'(ITER));

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = BUSY;
         end
         BUSY: begin
            busy = 1'b1;
            if (flush)     state_nxt = IDLE;
            else if (last) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (flush || out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Booth digit from {b[2i+1], b[2i], b[2i-1]}; the shift registers keep the triplet at bit 0.
   always_comb begin
      mag = '0;
      neg = 1'b0;
      unique case ({b_sh[1], b_sh[0], b_prev})
         3'b001, 3'b010: mag = a_sh;
         3'b011:         mag = a_sh << 1;
         3'b100: begin
            mag = a_sh << 1;
            neg = 1'b1;
         end
         3'b101, 3'b110: begin
            mag = a_sh;
            neg = 1'b1;
         end
         default:        mag = '0;
      endcase
      addend = neg ? (~mag + ACC_W'(1)) : mag;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         acc     <= '0;
         a_sh    <= '0;
         b_sh    <= '0;
         b_prev  <= 1'b0;
         cnt     <= '0;
         product <= '0;
      end else begin
         state <= state_nxt;
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sh   <= {{(ACC_W-N){signed_mode & mul_a[N-1]}}, mul_a};
                  b_sh   <= {{(XP-N){signed_mode & mul_b[N-1]}}, mul_b};
                  b_prev <= 1'b0;
                  acc    <= '0;
                  cnt    <= '0;
               end
            end
            BUSY: begin
               if (!flush) begin
                  if (last) begin
                     product <= acc[2*N-1:0];
                  end else begin
                     acc    <= acc + addend;
                     a_sh   <= a_sh << 2;
                     b_sh   <= b_sh >> 2;
                     b_prev <= b_sh[1];
                     cnt    <= cnt + CNT_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
